// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - fetch redirect control bundle: predictor, EX resolve, PC and status signals.
interface fetch_redirect_ctrl_if;
  logic        stall;
  logic        pred_sel;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pred_fallthru;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic        mispredict;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;
  logic        track_err;

  modport master (
    output stall, pred_sel, pred_taken, pred_target, pred_fallthru,
           res_valid, res_taken, res_target, jump_valid, jump_target,
    input  pc, mispredict, flush_if_id, flush_id_ex, branch_cnt, mispred_cnt, track_err
  );

  modport slave (
    input  stall, pred_sel, pred_taken, pred_target, pred_fallthru,
           res_valid, res_taken, res_target, jump_valid, jump_target,
    output pc, mispredict, flush_if_id, flush_id_ex, branch_cnt, mispred_cnt, track_err
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch PC owner with prediction tracker, mispredict recovery and branch counters.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          RESOLVE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_redirect_ctrl_if.slave  bus
);

  typedef struct packed {
    logic        v;
    logic        t;
    logic [31:0] tgt;
    logic [31:0] ft;
  } trk_t;

  trk_t        r_trk [RESOLVE_STAGES];
  logic [31:0] r_pc;
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;
  logic        r_track_err;

  trk_t        w_head;
  trk_t        w_fetch;
  logic        w_head_hit;
  logic        w_mispredict;
  logic        w_flush;
  logic [31:0] w_recover_pc;
  logic [31:0] w_next_pc;

  assign w_head       = r_trk[RESOLVE_STAGES-1];
  assign w_fetch      = '{v: bus.pred_sel, t: bus.pred_taken, tgt: bus.pred_target, ft: bus.pred_fallthru};
  assign w_head_hit   = bus.res_valid & w_head.v;
  // A taken branch is also wrong if it went somewhere other than where we fetched.
  assign w_mispredict = w_head_hit &
                        ((bus.res_taken != w_head.t) |
                         (bus.res_taken & (bus.res_target != w_head.tgt)));
  assign w_flush      = w_mispredict | bus.jump_valid;
  assign w_recover_pc = bus.res_taken ? bus.res_target : w_head.ft;

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (w_mispredict)        w_next_pc = w_recover_pc;
    else if (bus.jump_valid) w_next_pc = bus.jump_target;
    else if (bus.stall)      w_next_pc = r_pc;
    else if (bus.pred_sel)   w_next_pc = bus.pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
      r_track_err   <= 1'b0;
      for (int i = 0; i < RESOLVE_STAGES; i++) r_trk[i] <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_head_hit && (r_branch_cnt != '1))   r_branch_cnt  <= r_branch_cnt + 32'd1;
      if (w_mispredict && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 32'd1;
      if (bus.res_valid && !w_head.v)            r_track_err   <= 1'b1;
      // A redirect kills every younger fetch, so it wins over a stall.
      if (w_flush) begin
        for (int i = 0; i < RESOLVE_STAGES; i++) r_trk[i].v <= 1'b0;
      end else if (!bus.stall) begin
        for (int i = RESOLVE_STAGES-1; i > 0; i--) r_trk[i] <= r_trk[i-1];
        r_trk[0] <= w_fetch;
      end
    end
  end

  assign bus.pc          = r_pc;
  assign bus.mispredict  = w_mispredict;
  assign bus.flush_if_id = w_flush;
  assign bus.flush_id_ex = w_flush;
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;
  assign bus.track_err   = r_track_err;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed and randomized checks of fetch_redirect_ctrl against a queue model.
module tb_fetch_redirect_ctrl;
  localparam int RS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_redirect_ctrl_if bus ();
  fetch_redirect_ctrl #(.RESET_PC(32'h0), .RESOLVE_STAGES(RS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  // Model: in-flight predictions as a queue {valid, taken, target, fallthru}, oldest at the back.
  logic [65:0] m_q[$];
  logic [31:0] m_pc, m_bcnt, m_mcnt;
  logic        m_err;
  logic        e_mis, e_flush;
  logic [31:0] e_next;

  task automatic model_clear_q();
    m_q.delete();
    for (int i = 0; i < RS; i++) m_q.push_back('0);
  endtask

  task automatic model_eval();
    logic [65:0] h;
    h       = m_q[RS-1];
    e_mis   = bus.res_valid && h[65] &&
              ((bus.res_taken != h[64]) || (bus.res_taken && (bus.res_target != h[63:32])));
    e_flush = e_mis || bus.jump_valid;
    if (e_mis)               e_next = bus.res_taken ? bus.res_target : h[31:0];
    else if (bus.jump_valid) e_next = bus.jump_target;
    else if (bus.stall)      e_next = m_pc;
    else if (bus.pred_sel)   e_next = bus.pred_target;
    else                     e_next = m_pc + 32'd4;
  endtask

  task automatic tick();
    logic [65:0] h;
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_bcnt = 0; m_mcnt = 0; m_err = 1'b0;
      model_clear_q();
    end else begin
      h    = m_q[RS-1];
      m_pc = e_next;
      if (bus.res_valid && h[65] && (m_bcnt != 32'hFFFF_FFFF)) m_bcnt = m_bcnt + 1;
      if (e_mis && (m_mcnt != 32'hFFFF_FFFF)) m_mcnt = m_mcnt + 1;
      if (bus.res_valid && !h[65]) m_err = 1'b1;
      if (e_flush) model_clear_q();
      else if (!bus.stall) begin
        m_q.push_front({bus.pred_sel, bus.pred_taken, bus.pred_target, bus.pred_fallthru});
        void'(m_q.pop_back());
      end
    end
    #1;
  endtask

  task automatic drive(input logic st, input logic ps, input logic ptk, input logic [31:0] ptg,
                       input logic [31:0] pft, input logic rv, input logic rtk, input logic [31:0] rtg,
                       input logic jv, input logic [31:0] jt);
    @(negedge clk);
    bus.stall = st; bus.pred_sel = ps; bus.pred_taken = ptk; bus.pred_target = ptg;
    bus.pred_fallthru = pft; bus.res_valid = rv; bus.res_taken = rtk; bus.res_target = rtg;
    bus.jump_valid = jv; bus.jump_target = jt;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick();
    n_total++; if (bus.pc !== 32'h0) $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); else n_pass++;
    n_total++; if (bus.branch_cnt !== 32'h0 || bus.mispred_cnt !== 32'h0) $display("FAIL reset_cnt: got %h/%h expected 0/0", bus.branch_cnt, bus.mispred_cnt); else n_pass++;
    n_total++; if ({bus.mispredict, bus.flush_if_id, bus.flush_id_ex, bus.track_err} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {bus.mispredict, bus.flush_if_id, bus.flush_id_ex, bus.track_err}); else n_pass++;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      idle(); tick();
      n_total++; if (bus.pc !== 32'(i * 4)) $display("FAIL seq_pc: got %h expected %h", bus.pc, 32'(i * 4)); else n_pass++;
    end
  endtask

  task automatic test_prediction();
    idle(); tick();
    n_total++; if (bus.pc !== 32'h10) $display("FAIL pred_start_pc: got %h expected %h", bus.pc, 32'h10); else n_pass++;
    drive(0, 1, 1, 32'h40, 32'h14, 0, 0, 0, 0, 0); tick();
    n_total++; if (bus.pc !== 32'h40) $display("FAIL pred_pc: got %h expected %h", bus.pc, 32'h40); else n_pass++;
    idle(); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h40, 0, 0);
    n_total++; if (bus.mispredict !== 1'b0 || bus.flush_if_id !== 1'b0) $display("FAIL pred_noflush: got %b%b expected 00", bus.mispredict, bus.flush_if_id); else n_pass++;
    tick();
    n_total++; if (bus.branch_cnt !== 32'd1) $display("FAIL pred_bcnt: got %0d expected 1", bus.branch_cnt); else n_pass++;
  endtask

  task automatic test_mispredict();
    drive(0, 1, 1, 32'h40, 32'h14, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_total++; if ({bus.mispredict, bus.flush_if_id, bus.flush_id_ex} !== 3'b111) $display("FAIL mis_flags: got %b expected 111", {bus.mispredict, bus.flush_if_id, bus.flush_id_ex}); else n_pass++;
    tick();
    n_total++; if (bus.pc !== 32'h14) $display("FAIL mis_pc: got %h expected %h", bus.pc, 32'h14); else n_pass++;
    n_total++; if (bus.mispred_cnt !== 32'd1 || bus.branch_cnt !== 32'd2) $display("FAIL mis_cnt: got %0d/%0d expected 2/1", bus.branch_cnt, bus.mispred_cnt); else n_pass++;
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_total++; if (bus.mispredict !== 1'b0) $display("FAIL mis_cleared: got %b expected 0", bus.mispredict); else n_pass++;
    tick();
    n_total++; if (bus.track_err !== 1'b1 || bus.branch_cnt !== 32'd2) $display("FAIL mis_cleared_err: got %b/%0d expected 1/2", bus.track_err, bus.branch_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = bus.pc;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 32'h40, 32'h1c, 0, 0, 0, 0, 0); tick();
      n_total++; if (bus.pc !== held) $display("FAIL stall_hold: got %h expected %h", bus.pc, held); else n_pass++;
    end
    drive(0, 1, 1, 32'h40, 32'h1c, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    n_total++; if (bus.pc !== 32'h40) $display("FAIL stall_hold2: got %h expected %h", bus.pc, 32'h40); else n_pass++;
    idle(); tick();
    drive(1, 0, 0, 0, 0, 1, 1, 32'h60, 0, 0);
    n_total++; if (bus.mispredict !== 1'b1) $display("FAIL stall_mis: got %b expected 1", bus.mispredict); else n_pass++;
    tick();
    n_total++; if (bus.pc !== 32'h60) $display("FAIL stall_redirect: got %h expected %h", bus.pc, 32'h60); else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(0, 1, 1, 32'h40, 32'h64, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h40, 1, 32'h80);
    n_total++; if (bus.mispredict !== 1'b0 || bus.flush_id_ex !== 1'b1) $display("FAIL sim_jump_flags: got %b%b expected 01", bus.mispredict, bus.flush_id_ex); else n_pass++;
    tick();
    n_total++; if (bus.pc !== 32'h80) $display("FAIL sim_jump_pc: got %h expected %h", bus.pc, 32'h80); else n_pass++;
    drive(0, 1, 1, 32'h40, 32'h84, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h80); tick();
    n_total++; if (bus.pc !== 32'h84) $display("FAIL sim_recover_wins: got %h expected %h", bus.pc, 32'h84); else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC); tick();
    idle(); tick();
    n_total++; if (bus.pc !== 32'h0) $display("FAIL pc_wrap: got %h expected %h", bus.pc, 32'h0); else n_pass++;
  endtask

  task automatic test_track_err();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 1, 32'h40, 0, 0);
    n_total++; if (bus.mispredict !== 1'b0) $display("FAIL err_nomis: got %b expected 0", bus.mispredict); else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
    n_total++; if (bus.track_err !== 1'b1 || bus.branch_cnt !== 32'd0) $display("FAIL err_sticky: got %b/%0d expected 1/0", bus.track_err, bus.branch_cnt); else n_pass++;
  endtask

  task automatic test_saturation();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    @(negedge clk);
    force dut.r_branch_cnt  = 32'hFFFF_FFFE;
    force dut.r_mispred_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_branch_cnt;
    release dut.r_mispred_cnt;
    m_bcnt = 32'hFFFF_FFFE; m_mcnt = 32'hFFFF_FFFE;
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 1, 32'h40, 32'h100, 0, 0, 0, 0, 0); tick();
      idle(); tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); tick();
      n_total++; if (bus.branch_cnt !== 32'hFFFF_FFFF || bus.mispred_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_cnt%0d: got %h/%h expected ffffffff/ffffffff", k, bus.branch_cnt, bus.mispred_cnt); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [65:0] h;
    logic        rv, rtk;
    logic [31:0] rtg;
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      h   = m_q[RS-1];
      rv  = ($urandom_range(0, 2) == 0);
      rtk = ($urandom_range(0, 1) == 1) ? h[64] : 1'($urandom);
      rtg = ($urandom_range(0, 1) == 1) ? h[63:32] : ($urandom & 32'h0000_00FC);
      rst = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), $urandom & 32'h0000_0FFC,
            $urandom & 32'h0000_0FFC, rv, rtk, rtg, ($urandom_range(0, 9) == 0), $urandom & 32'h0000_0FFC);
      model_eval();
      n_total++; if ({bus.mispredict, bus.flush_if_id, bus.flush_id_ex} !== {e_mis, e_flush, e_flush}) $display("FAIL rnd_comb[%0d]: got %b expected %b", i, {bus.mispredict, bus.flush_if_id, bus.flush_id_ex}, {e_mis, e_flush, e_flush}); else n_pass++;
      tick();
      n_total++; if (bus.pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %h expected %h", i, bus.pc, m_pc); else n_pass++;
      n_total++; if ({bus.branch_cnt, bus.mispred_cnt, bus.track_err} !== {m_bcnt, m_mcnt, m_err}) $display("FAIL rnd_state[%0d]: got %h/%h/%b expected %h/%h/%b", i, bus.branch_cnt, bus.mispred_cnt, bus.track_err, m_bcnt, m_mcnt, m_err); else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_pc = 0; m_bcnt = 0; m_mcnt = 0; m_err = 1'b0;
    model_clear_q();
    test_reset();
    test_prediction();
    test_mispredict();
    test_stall();
    test_simultaneous();
    test_track_err();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
